decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_pkg.sv | 45 ++++
 rtl/rv32i_field_decode.sv | 181 ++++++++++++++++++
 rtl/decode_queue.sv | 100 ++++++++++
 tb/tb_decode_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared RV32I constants and types for the decode queue.
// Opcodes, funct7 patterns, operation encodings and entry layout.
package decode_queue_pkg;

  localparam int OPT_W = 6;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [OPT_W-1:0] {
    OPTYPE_ILLEGAL,
    OPTYPE_LUI, OPTYPE_AUIPC, OPTYPE_JAL, OPTYPE_JALR,
    OPTYPE_BEQ, OPTYPE_BNE, OPTYPE_BLT, OPTYPE_BGE,
    OPTYPE_BLTU, OPTYPE_BGEU,
    OPTYPE_LB, OPTYPE_LH, OPTYPE_LW, OPTYPE_LBU, OPTYPE_LHU,
    OPTYPE_SB, OPTYPE_SH, OPTYPE_SW,
    OPTYPE_ADDI, OPTYPE_SLTI, OPTYPE_SLTIU, OPTYPE_XORI,
    OPTYPE_ORI, OPTYPE_ANDI,
    OPTYPE_SLLI, OPTYPE_SRLI, OPTYPE_SRAI,
    OPTYPE_ADD, OPTYPE_SUB, OPTYPE_SLL, OPTYPE_SLT,
    OPTYPE_SLTU, OPTYPE_XOR, OPTYPE_SRL, OPTYPE_SRA,
    OPTYPE_OR, OPTYPE_AND,
    OPTYPE_FENCE, OPTYPE_SYSTEM
  } optype_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

endpackage

// File: rtl/rv32i_field_decode.sv
// Combinational RV32I field decoder: instruction word to
// operation type, register indices, immediate and flags.
module rv32i_field_decode
  import decode_queue_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic [OPT_W-1:0] optype_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [31:0]      imm_o,
  output logic             is_ls_o,
  output logic             is_jump_o,
  output logic             illegal_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b;
  logic [31:0] imm_u, imm_j, imm_sh;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25],
                   instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31],
                   instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'h000};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31],
                   instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
  assign imm_sh = {27'd0, instr_i[24:20]};

  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];

  optype_e     opt;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        ls, jmp, ill;

  always_comb begin
    opt = OPTYPE_ILLEGAL;
    rd  = instr_i[11:7];
    imm = '0;
    ls  = 1'b0;
    jmp = 1'b0;
    ill = 1'b0;
    unique case (opc)
      OP_LUI: begin
        opt = OPTYPE_LUI;
        imm = imm_u;
      end
      OP_AUIPC: begin
        opt = OPTYPE_AUIPC;
        imm = imm_u;
      end
      OP_JAL: begin
        opt = OPTYPE_JAL;
        imm = imm_j;
        jmp = 1'b1;
      end
      OP_JALR: begin
        opt = OPTYPE_JALR;
        imm = imm_i;
        jmp = 1'b1;
      end
      OP_BRANCH: begin
        rd  = REG_ZERO;
        imm = imm_b;
        jmp = 1'b1;
        unique case (f3)
          3'b000:  opt = OPTYPE_BEQ;
          3'b001:  opt = OPTYPE_BNE;
          3'b100:  opt = OPTYPE_BLT;
          3'b101:  opt = OPTYPE_BGE;
          3'b110:  opt = OPTYPE_BLTU;
          3'b111:  opt = OPTYPE_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        imm = imm_i;
        ls  = 1'b1;
        unique case (f3)
          3'b000:  opt = OPTYPE_LB;
          3'b001:  opt = OPTYPE_LH;
          3'b010:  opt = OPTYPE_LW;
          3'b100:  opt = OPTYPE_LBU;
          3'b101:  opt = OPTYPE_LHU;
          default: ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        rd  = REG_ZERO;
        imm = imm_s;
        ls  = 1'b1;
        unique case (f3)
          3'b000:  opt = OPTYPE_SB;
          3'b001:  opt = OPTYPE_SH;
          3'b010:  opt = OPTYPE_SW;
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        imm = imm_i;
        unique case (f3)
          3'b000: opt = OPTYPE_ADDI;
          3'b010: opt = OPTYPE_SLTI;
          3'b011: opt = OPTYPE_SLTIU;
          3'b100: opt = OPTYPE_XORI;
          3'b110: opt = OPTYPE_ORI;
          3'b111: opt = OPTYPE_ANDI;
          3'b001: begin
            imm = imm_sh;
            opt = OPTYPE_SLLI;
            ill = (f7 != F7_BASE);
          end
          default: begin
            imm = imm_sh;
            opt = OPTYPE_SRLI;
            if (f7 == F7_ALT) opt = OPTYPE_SRAI;
            else ill = (f7 != F7_BASE);
          end
        endcase
      end
      OP_REG: begin
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'b000:  opt = OPTYPE_ADD;
            3'b001:  opt = OPTYPE_SLL;
            3'b010:  opt = OPTYPE_SLT;
            3'b011:  opt = OPTYPE_SLTU;
            3'b100:  opt = OPTYPE_XOR;
            3'b101:  opt = OPTYPE_SRL;
            3'b110:  opt = OPTYPE_OR;
            default: opt = OPTYPE_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          unique case (f3)
            3'b000:  opt = OPTYPE_SUB;
            3'b101:  opt = OPTYPE_SRA;
            default: ill = 1'b1;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      OP_FENCE: begin
        opt = OPTYPE_FENCE;
        imm = imm_i;
      end
      OP_SYSTEM: begin
        opt = OPTYPE_SYSTEM;
        imm = imm_i;
      end
      default: ill = 1'b1;
    endcase
    // undecodable entries carry no side-effect-bearing fields
    if (ill) begin
      opt = OPTYPE_ILLEGAL;
      rd  = REG_ZERO;
      imm = '0;
      ls  = 1'b0;
      jmp = 1'b0;
    end
  end

  assign optype_o  = opt;
  assign rd_o      = rd;
  assign imm_o     = imm;
  assign is_ls_o   = ls;
  assign is_jump_o = jmp;
  assign illegal_o = ill;

endmodule

// File: rtl/decode_queue.sv
// Instruction queue between fetch and issue; decodes the
// head entry combinationally on the way out.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [OPT_W-1:0] out_optype,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_is_ls,
  output logic             out_is_jump,
  output logic             out_illegal,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   push, pop, has_head;
  entry_t head_e;

  assign has_head  = (count_q != '0);
  assign in_ready  = rdy_in && rst_in && !flush &&
                     (count_q != CNT_W'(DEPTH));
  assign out_valid = rdy_in && rst_in && has_head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[tail_q] <= '{instr: in_instr, pc: in_pc};
  end

  // an empty queue presents an all-zero entry so outputs stay defined
  assign head_e = has_head ? mem_q[head_q] : '0;
  assign out_pc = head_e.pc;

  rv32i_field_decode u_dec (
    .instr_i   (head_e.instr),
    .optype_o  (out_optype),
    .rd_o      (out_rd),
    .rs1_o     (out_rs1),
    .rs2_o     (out_rs2),
    .imm_o     (out_imm),
    .is_ls_o   (out_is_ls),
    .is_jump_o (out_is_jump),
    .illegal_o (out_illegal)
  );

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: queue control and decode.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, flush;
  logic             in_valid, out_ready;
  logic [31:0]      in_instr, in_pc;
  logic             in_ready, out_valid;
  logic [31:0]      out_pc, out_imm;
  logic [OPT_W-1:0] out_optype;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic             out_is_ls, out_is_jump, out_illegal;
  logic [2:0]       count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_in = ~clk_in;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_optype  (out_optype),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_is_ls   (out_is_ls),
    .out_is_jump (out_is_jump),
    .out_illegal (out_illegal),
    .count       (count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] addi(input int n);
    return (32'(n) << 20) | (32'(n & 31) << 7) | 32'h13;
  endfunction

  task automatic push1(input logic [31:0] ins,
                       input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic vec(input string tag,
                     input logic [31:0] ins,
                     input optype_e opt,
                     input logic [4:0] rd,
                     input logic [31:0] imm,
                     input logic ls, jmp, ill);
    push1(ins, 32'h300);
    chk({tag, ".opt"}, 32'(out_optype), 32'(opt));
    chk({tag, ".rd"},  32'(out_rd), 32'(rd));
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".ls"},  32'(out_is_ls), 32'(ls));
    chk({tag, ".jmp"}, 32'(out_is_jump), 32'(jmp));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
    pop1();
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.noX", 32'($isunknown({out_pc, out_optype,
        out_rd, out_rs1, out_rs2, out_imm, out_is_ls,
        out_is_jump, out_illegal})), 0);
    rst_in = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 1);

    // first push visible next cycle
    push1(32'hFFF00093, 32'h100);
    chk("addi.valid", 32'(out_valid), 1);
    chk("addi.opt", 32'(out_optype), 32'(OPTYPE_ADDI));
    chk("addi.rd", 32'(out_rd), 1);
    chk("addi.rs1", 32'(out_rs1), 0);
    chk("addi.imm", out_imm, 32'hFFFFFFFF);
    chk("addi.pc", out_pc, 32'h100);
    pop1();
    chk("addi.drain", 32'(count), 0);

    // fill to full, then pop with push held
    for (int k = 0; k < DEPTH; k++)
      push1(addi(k), 32'h200 + 32'(4 * k));
    in_valid = 1'b1;
    in_instr = addi(9);
    in_pc    = 32'h2F0;
    #1;
    chk("full.count", 32'(count), DEPTH);
    chk("full.in_ready", 32'(in_ready), 0);
    pop1();
    in_valid = 1'b0;
    chk("full.pop_count", 32'(count), DEPTH - 1);
    out_ready = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      chk("full.order", out_pc, 32'h200 + 32'(4 * k));
      step();
    end
    out_ready = 1'b0;
    chk("full.empty", 32'(count), 0);

    // steady push+pop across pointer wrap
    push1(addi(0), 32'h1000);
    push1(addi(1), 32'h1004);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      in_instr = addi(k + 2);
      in_pc    = 32'h1000 + 32'(4 * (k + 2));
      #1;
      chk("wrap.pc", out_pc, 32'h1000 + 32'(4 * k));
      chk("wrap.rd", 32'(out_rd), 32'(k & 31));
      step();
      chk("wrap.count", 32'(count), 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // flush with concurrent push and pop
    push1(addi(20), 32'h1100);
    chk("flush.pre", 32'(count), 3);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_instr = addi(21);
    in_pc = 32'h1104;
    #1;
    chk("flush.in_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush.count", 32'(count), 0);
    chk("flush.valid", 32'(out_valid), 0);

    // decode vectors
    vec("br010", 32'h00002063, OPTYPE_ILLEGAL, 0, 0, 0, 0, 1);
    vec("zero", 32'h00000000, OPTYPE_ILLEGAL, 0, 0, 0, 0, 1);
    vec("beq", 32'h00000063, OPTYPE_BEQ, 0, 0, 0, 1, 0);
    vec("lui", 32'h123450B7, OPTYPE_LUI, 1,
        32'h12345000, 0, 0, 0);
    vec("jal", 32'hFFDFF0EF, OPTYPE_JAL, 1,
        32'hFFFFFFFC, 0, 1, 0);
    vec("bne", 32'hFE209CE3, OPTYPE_BNE, 0,
        32'hFFFFFFF8, 0, 1, 0);
    vec("sw", 32'h0020A423, OPTYPE_SW, 0, 8, 1, 0, 0);
    vec("lw", 32'hFF812203, OPTYPE_LW, 4,
        32'hFFFFFFF8, 1, 0, 0);
    vec("srai", 32'h4051D193, OPTYPE_SRAI, 3, 5, 0, 0, 0);
    vec("slli_f7", 32'h40519193, OPTYPE_ILLEGAL, 0, 0, 0, 0, 1);
    vec("sub", 32'h407302B3, OPTYPE_SUB, 5, 0, 0, 0, 0);
    vec("ld011", 32'h00003003, OPTYPE_ILLEGAL, 0, 0, 0, 0, 1);
    chk("vec.empty", 32'(count), 0);

    // stall: everything frozen, flush ignored
    push1(addi(3), 32'h400);
    push1(addi(4), 32'h404);
    rdy_in = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_instr = addi(5);
    in_pc = 32'h408;
    #1;
    chk("stall.in_ready", 32'(in_ready), 0);
    chk("stall.out_valid", 32'(out_valid), 0);
    repeat (5) step();
    rdy_in = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("stall.count", 32'(count), 2);
    chk("stall.head", out_pc, 32'h400);

    // reset mid-fill
    push1(addi(6), 32'h40C);
    chk("midrst.pre", 32'(count), 3);
    rst_in = 1'b0;
    step();
    chk("midrst.count", 32'(count), 0);
    chk("midrst.valid", 32'(out_valid), 0);
    rst_in = 1'b1;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
